// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter draining a first-word-fall-through FIFO; o_tx is a flop,
// o_fifo_rd pops the head word when a frame is launched.
module uart_tx_fifo #(
  parameter int B         = 8,
  parameter int DVSR      = 868,
  parameter int STOP_BITS = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_fifo_empty,
  input  logic [B-1:0] i_fifo_data,
  output logic         o_fifo_rd,
  output logic         o_tx,
  output logic         o_tx_busy,
  output logic         o_tx_done_tick
);

  localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int BW = $clog2(B);
  localparam logic [TW-1:0] TICK_MAX = TW'(DVSR - 1);
  localparam logic [BW-1:0] DATA_MAX = BW'(B - 1);
  localparam logic [BW-1:0] STOP_MAX = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [BW-1:0] r_bit;
  logic [B-1:0]  r_shift;
  logic          r_tx;

  logic w_tick_last;
  logic w_stop_last;
  logic w_load;

  assign w_tick_last = (r_tick == TICK_MAX);
  assign w_stop_last = (r_state == STOP) && w_tick_last && (r_bit == STOP_MAX);
  // A new word is taken either from idle or on the final stop cycle, so frames chain without a gap.
  assign w_load      = !i_fifo_empty && ((r_state == IDLE) || w_stop_last);

  assign o_fifo_rd      = w_load & i_reset_n;
  assign o_tx           = r_tx;
  assign o_tx_busy      = (r_state != IDLE);
  assign o_tx_done_tick = w_stop_last;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_tick <= '0;
          r_bit  <= '0;
          if (w_load) begin
            r_shift <= i_fifo_data;
            r_state <= START;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          if (w_tick_last) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        DATA: begin
          if (w_tick_last) begin
            r_tick <= '0;
            if (r_bit == DATA_MAX) begin
              r_bit   <= '0;
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_tick_last) begin
            r_tick <= '0;
            if (r_bit == STOP_MAX) begin
              r_bit <= '0;
              if (w_load) begin
                r_shift <= i_fifo_data;
                r_state <= START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmitter that drains the 8-bit UART FIFO's read side (first-word-fall-through: data valid whenever the FIFO is not empty) and serialises each word onto the TX line. The frame is 8N1 by default: one start bit, B data bits LSB first, and STOP_BITS stop bits, each bit DVSR clocks long. It is the consumer/read end of the FIFO in the UART Basic path, counterpart to the receiver that writes the RX FIFO.

Parameters:
B, 8, data bits per frame and FIFO word width (5..9)
DVSR, 868, clock cycles per bit (100 MHz / 115200); must be >= 2
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
i_clk  input  1  system clock, rising-edge
i_reset_n  input  1  asynchronous active-low reset
i_fifo_empty  input  1  FIFO empty flag
i_fifo_data  input  B  FIFO head word, valid while i_fifo_empty=0
o_fifo_rd  output  1  FIFO pop strobe, one cycle per word, combinational
o_tx  output  1  serial line, registered, idle high
o_tx_busy  output  1  high whenever state != IDLE
o_tx_done_tick  output  1  one-cycle pulse on the last cycle of each stop period

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done_tick=0, all counters=0. o_fifo_rd is forced 0 while reset is asserted.
- States: IDLE, START, DATA, STOP. Counters: tick_cnt runs 0..DVSR-1 and width is clog2(DVSR). bit_cnt runs 0..B-1 in DATA and 0..STOP_BITS-1 in STOP. The shift register is B bits wide.
- IDLE: o_tx=1. If i_fifo_empty=0:
  - o_fifo_rd=1 in that same cycle.
  - At the clock edge, latch i_fifo_data into the shift register, go to START, set o_tx<=0, clear tick_cnt.
  - Latency: o_tx falls on the first rising edge after empty deasserts.
- START: o_tx=0 for DVSR cycles. When tick_cnt=DVSR-1: go to DATA, o_tx<=shift[0], bit_cnt=0.
- DATA: each bit is held DVSR cycles. At tick_cnt=DVSR-1:
  - If bit_cnt<B-1: shift right, o_tx<=next LSB, bit_cnt+1.
  - Otherwise: go to STOP, o_tx<=1, bit_cnt=0.
- STOP: o_tx=1 for STOP_BITS*DVSR cycles. On its final cycle:
  - o_tx_done_tick=1.
  - If i_fifo_empty=0: o_fifo_rd=1 in that cycle, latch the new word, go directly to START (back-to-back frames, no extra idle cycle).
  - Otherwise go to IDLE.
- o_fifo_rd is never asserted outside those two conditions. There is exactly one pop per transmitted frame, and it is never asserted while empty=1.
- Frame length is (1+B+STOP_BITS)*DVSR cycles exactly. Frames run with no jitter and no drift.
- i_fifo_data and i_fifo_empty changes mid-frame are ignored; only the latched word is sent.
- Reset mid-frame: the line returns high immediately (asynchronously). The partial word is discarded and not re-popped. After release the block restarts from IDLE.
- o_tx is a flop output; no combinational path from inputs to o_tx.

Test Plan:
- Idle: DVSR=4, hold i_fifo_empty=1 for 100 cycles -> o_tx=1, o_fifo_rd=0, o_tx_busy=0 throughout.
- Single byte: DVSR=4, STOP_BITS=1, FIFO holds 0xA5 -> exactly one o_fifo_rd pulse. o_tx is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. o_tx_done_tick pulses once, 40 cycles after the start edge. busy is high for those 40 cycles.
- Back-to-back: FIFO holds 0x00 then 0xFF -> two rd pulses, 40 cycles apart. The second start bit immediately follows the first frame's stop, with no extra high cycle. A bench UART model decodes 0x00, 0xFF.
- Two stop bits: STOP_BITS=2, DVSR=4, byte 0x3C -> stop period of 8 cycles, frame of 44 cycles, done tick on the 44th cycle.
- Reset mid-frame: assert i_reset_n=0 during data bit 3 -> o_tx=1 in the same cycle, busy=0. After release with FIFO non-empty, the next word is popped and sent cleanly. Total pops equal frames started.
- Empty mid-stop: FIFO goes empty during the first frame -> return to IDLE after stop with no spurious rd. A later non-empty starts a frame one edge after empty deasserts.
